// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Serialises the pipeline's instruction-fetch and data-access requests
//   onto a single request/acknowledge bus. Data accesses win when both are
//   pending. Completed accesses of the current pipeline cycle are remembered
//   so that the pipeline can stall until every request it presented is served.
//   A flush turns an in-flight access into an abort that waits out the bus
//   handshake and throws the result away. A wait counter bounds every access
//   and reports an expiry on bus_err.
//
// Ports
//   clk, rst             clock, synchronous active-low reset
//   if_req, if_addr      instruction fetch request and address
//   if_rdata             registered fetched word
//   mem_req, mem_we      data access request and direction (1 = write)
//   mem_sel              byte enables
//   mem_addr, mem_wdata  data address and write data
//   mem_rdata            registered read word
//   flush                pipeline flush, discards pending results
//   stallreq_from_bus    combinational stall request to the pipeline control
//   bus_req, bus_we      registered bus strobe and direction
//   bus_sel, bus_addr,
//   bus_wdata            registered bus payload
//   bus_rdata, bus_ack   bus read data and completion
//   bus_err              one-cycle pulse when an access times out
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        stallreq_from_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, INST, ABORT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          data_done;
  logic          inst_done;
  logic [CW-1:0] wait_cnt;

  logic data_pend;
  logic inst_pend;
  logic at_limit;
  logic data_ok;
  logic inst_ok;
  logic data_to;
  logic inst_to;
  logic abort_to;
  logic load_data;
  logic load_inst;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. A flush wins over a timeout on the same edge so that
  // the squashed access is retired through ABORT rather than reported.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!flush && data_pend)      state_nxt = DATA;
        else if (!flush && inst_pend) state_nxt = INST;
      end
      DATA: begin
        if (bus_ack) begin
          if (!flush && inst_pend) state_nxt = INST;
          else                     state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = ABORT;
        end else if (at_limit) begin
          state_nxt = IDLE;
        end
      end
      INST: begin
        if (bus_ack)       state_nxt = IDLE;
        else if (flush)    state_nxt = ABORT;
        else if (at_limit) state_nxt = IDLE;
      end
      ABORT: begin
        if (bus_ack || at_limit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs and event decodes shared by the datapath
  always_comb begin
    data_pend         = mem_req & ~data_done;
    inst_pend         = if_req & ~inst_done;
    stallreq_from_bus = (data_pend | inst_pend) & ~flush;
    at_limit          = (wait_cnt >= LIMIT);
    data_ok           = (state == DATA) & bus_ack & ~flush;
    inst_ok           = (state == INST) & bus_ack & ~flush;
    data_to           = (state == DATA) & ~bus_ack & ~flush & at_limit;
    inst_to           = (state == INST) & ~bus_ack & ~flush & at_limit;
    abort_to          = (state == ABORT) & ~bus_ack & at_limit;
    load_data         = (state == IDLE) & (state_nxt == DATA);
    load_inst         = (state != INST) & (state_nxt == INST);
  end

  // Bus payload, wait counter, result registers and completion flags.
  // The counter saturates at its limit so an access that is flushed on the
  // same edge it would have expired still expires on the next edge in ABORT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b0;
      bus_addr  <= 32'b0;
      bus_wdata <= 32'b0;
      if_rdata  <= 32'b0;
      mem_rdata <= 32'b0;
      data_done <= 1'b0;
      inst_done <= 1'b0;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_req <= (state_nxt != IDLE);
      bus_err <= data_to | inst_to | abort_to;

      if (load_data) begin
        bus_we    <= mem_we;
        bus_sel   <= mem_sel;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
      end else if (load_inst) begin
        bus_we   <= 1'b0;
        bus_sel  <= 4'b1111;
        bus_addr <= if_addr;
      end

      if (load_data || load_inst)          wait_cnt <= '0;
      else if (bus_req && !bus_ack && !at_limit) wait_cnt <= wait_cnt + 1'b1;

      if (data_ok && !bus_we)      mem_rdata <= bus_rdata;
      else if (data_to && !bus_we) mem_rdata <= 32'b0;

      if (inst_ok)      if_rdata <= bus_rdata;
      else if (inst_to) if_rdata <= 32'b0;

      // Flags only survive while the pipeline is held.
      if (!stallreq_from_bus) begin
        data_done <= 1'b0;
        inst_done <= 1'b0;
      end else begin
        if (data_ok || data_to) data_done <= 1'b1;
        if (inst_ok || inst_to) inst_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Drives bus_arbiter with a few fixed scenarios followed by randomized
//   pipeline traffic, flushes, resets and bus acknowledge timing. A
//   transaction-level model of the arbiter predicts every output.
module tb_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        stallreq_from_bus;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .flush(flush), .stallreq_from_bus(stallreq_from_bus),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one in-flight access record plus the completion flags.
  bit          m_init = 0;
  bit          m_busy, m_inst, m_drop, m_dd, m_id, m_err, m_we;
  int          m_wait;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_ifr, m_memr;
  bit          last_adv;

  // Bus slave behaviour: 0 = random acknowledge, otherwise fixed latency
  int          ack_lat = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_rdata = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit modelStall();
    return ((mem_req && !m_dd) || (if_req && !m_id)) && !flush;
  endfunction

  task automatic startData();
    m_busy = 1; m_inst = 0; m_drop = 0; m_wait = 0;
    m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
  endtask

  task automatic startInst();
    m_busy = 1; m_inst = 1; m_drop = 0; m_wait = 0;
    m_we = 0; m_sel = 4'hF; m_addr = if_addr;
  endtask

  task automatic modelStep();
    bit stall, was_busy;
    if (!rst) begin
      m_busy = 0; m_inst = 0; m_drop = 0; m_dd = 0; m_id = 0; m_err = 0;
      m_we = 0; m_wait = 0; m_sel = 0; m_addr = 0; m_wdata = 0;
      m_ifr = 0; m_memr = 0; m_init = 1; last_adv = 1;
      return;
    end
    stall    = modelStall();
    last_adv = !stall;
    was_busy = m_busy;
    m_err    = 0;
    if (m_busy) begin
      if (bus_ack) begin
        if (!m_drop && !flush) begin
          if (!m_inst) begin
            if (!m_we) m_memr = bus_rdata;
            m_dd = 1;
            if (if_req && !m_id) startInst();
            else m_busy = 0;
          end else begin
            m_ifr = bus_rdata; m_id = 1; m_busy = 0;
          end
        end else begin
          m_busy = 0;
        end
      end else if (flush && !m_drop) begin
        m_drop = 1; m_wait++;
      end else if (m_wait >= T - 1) begin
        m_busy = 0; m_err = 1;
        if (!m_drop) begin
          if (!m_inst) begin
            if (!m_we) m_memr = 32'h0;
            m_dd = 1;
          end else begin
            m_ifr = 32'h0; m_id = 1;
          end
        end
      end else begin
        m_wait++;
      end
    end
    if (!was_busy && !flush) begin
      if (mem_req && !m_dd)     startData();
      else if (if_req && !m_id) startInst();
    end
    if (!stall) begin
      m_dd = 0; m_id = 0;
    end
  endtask

  task automatic driveAck();
    bit ack;
    if (ack_lat == 0) ack = m_busy && ($urandom_range(0, 99) < 35);
    else              ack = m_busy && (m_wait >= ack_lat - 1);
    bus_ack   = ack;
    bus_rdata = use_fixed ? fixed_rdata : $urandom;
  endtask

  // One clock cycle with the inputs currently applied.
  task automatic applyStimulus();
    @(negedge clk);
    if (m_init) checkOutput("stallreq", stallreq_from_bus, modelStall());
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("bus_req",   bus_req,   m_busy);
    checkOutput("bus_err",   bus_err,   m_err);
    checkOutput("bus_we",    bus_we,    m_we);
    checkOutput("bus_sel",   bus_sel,   m_sel);
    checkOutput("bus_addr",  bus_addr,  m_addr);
    checkOutput("bus_wdata", bus_wdata, m_wdata);
    checkOutput("if_rdata",  if_rdata,  m_ifr);
    checkOutput("mem_rdata", mem_rdata, m_memr);
    driveAck();
  endtask

  task automatic idleInputs();
    if_req = 0; mem_req = 0; mem_we = 0; mem_sel = 0; flush = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
  endtask

  initial begin
    int req_cycles, err_cycles;
    rst = 0; bus_ack = 0; bus_rdata = 0;
    idleInputs();
    applyStimulus();
    applyStimulus();
    checkOutput("rst_bus_req",  bus_req,   0);
    checkOutput("rst_bus_sel",  bus_sel,   0);
    checkOutput("rst_if_rdata", if_rdata,  0);
    checkOutput("rst_mem_rdata", mem_rdata, 0);
    rst = 1;
    applyStimulus();

    // Single fetch, acknowledged two cycles after the strobe
    ack_lat = 2; use_fixed = 1; fixed_rdata = 32'h24020001;
    if_req = 1; if_addr = 32'h80000000;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (bus_req) req_cycles++;
      if (last_adv) break;
    end
    checkOutput("fetch_complete", last_adv, 1);
    checkOutput("fetch_req_cycles", req_cycles, 2);
    checkOutput("fetch_rdata", if_rdata, 32'h24020001);
    idleInputs();
    applyStimulus();

    // Data read and fetch in the same pipeline cycle
    ack_lat = 1; fixed_rdata = 32'hCAFE0001;
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h80400000;
    if_req = 1; if_addr = 32'h80000004;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (last_adv) break;
    end
    checkOutput("both_complete", last_adv, 1);
    checkOutput("both_mem_rdata", mem_rdata, 32'hCAFE0001);
    idleInputs();
    applyStimulus();

    // Partial write leaves the read register alone
    mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h80400010;
    mem_wdata = 32'h1234ABCD; fixed_rdata = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("write_we",  bus_we,  1);
    checkOutput("write_sel", bus_sel, 4'b0011);
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (last_adv) break;
    end
    checkOutput("write_mem_rdata", mem_rdata, 32'hCAFE0001);
    idleInputs();
    applyStimulus();

    // Fetch that is never acknowledged
    ack_lat = 100;
    if_req = 1; if_addr = 32'h80000008;
    req_cycles = 0; err_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (bus_req) req_cycles++;
      if (bus_err) err_cycles++;
      if (last_adv) break;
    end
    checkOutput("timeout_complete", last_adv, 1);
    checkOutput("timeout_req_cycles", req_cycles, T);
    checkOutput("timeout_err_pulses", err_cycles, 1);
    checkOutput("timeout_if_rdata", if_rdata, 0);
    idleInputs();
    applyStimulus();

    // Randomized traffic
    ack_lat = 0; use_fixed = 0;
    for (int i = 0; i < 4000; i++) begin
      if (last_adv) begin
        mem_req   = $urandom_range(0, 99) < 50;
        mem_we    = $urandom_range(0, 1);
        mem_sel   = 4'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        if_req    = $urandom_range(0, 99) < 70;
        if_addr   = $urandom;
      end
      flush = $urandom_range(0, 99) < 6;
      rst   = !($urandom_range(0, 199) == 0);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
